// File: rtl/fft_dual_port_mem.sv
// Two-write/two-read working memory for the 16-point FFT with registered reads,
// bit-reversed load addressing and self-clear; define FFT_MEM_FWD_EN for write-first reads.
module fft_dual_port_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              collision,
    input  logic              bitrev_en,
    input  logic [ADDR_W-1:0] write_addr_1,
    input  logic [DATA_W-1:0] write_data_1,
    input  logic              write_en_1,
    input  logic [ADDR_W-1:0] write_addr_2,
    input  logic [DATA_W-1:0] write_data_2,
    input  logic              write_en_2,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_2
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clear_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] eff_addr_1;
    logic              same_addr;
    logic              wr_1;
    logic              wr_2;
    logic              hit;
    logic [DATA_W-1:0] rd_next_1;
    logic [DATA_W-1:0] rd_next_2;

    function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (&clear_cnt) state_next = IDLE;
            IDLE:    if (clear_req) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_cnt <= '0;
        end else if (state == CLEAR) begin
            clear_cnt <= clear_cnt + 1'b1;
        end else if (clear_req) begin
            clear_cnt <= '0;
        end
    end

    // Port 2 wins a same-address write, so port 1 is suppressed rather than racing it.
    always_comb begin
        eff_addr_1 = bitrev_en ? bit_reverse(write_addr_1) : write_addr_1;
        same_addr  = (eff_addr_1 == write_addr_2);
        wr_2       = !busy && write_en_2;
        wr_1       = !busy && write_en_1 && !(write_en_2 && same_addr);
        hit        = !busy && write_en_1 && write_en_2 && same_addr;
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clear_cnt] <= '0;
        end else begin
            if (wr_1) mem[eff_addr_1] <= write_data_1;
            if (wr_2) mem[write_addr_2] <= write_data_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else if (!busy) begin
            if (clear_req) begin
                collision <= 1'b0;
            end else if (hit) begin
                collision <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_next_1 = mem[read_addr_1];
        rd_next_2 = mem[read_addr_2];
`ifdef FFT_MEM_FWD_EN
        if (wr_2 && write_addr_2 == read_addr_1) begin
            rd_next_1 = write_data_2;
        end else if (wr_1 && eff_addr_1 == read_addr_1) begin
            rd_next_1 = write_data_1;
        end
        if (wr_2 && write_addr_2 == read_addr_2) begin
            rd_next_2 = write_data_2;
        end else if (wr_1 && eff_addr_1 == read_addr_2) begin
            rd_next_2 = write_data_1;
        end
`endif
        if (busy) begin
            rd_next_1 = '0;
            rd_next_2 = '0;
        end
    end

    // Read output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_1 <= '0;
            read_data_2 <= '0;
        end else begin
            read_data_1 <= rd_next_1;
            read_data_2 <= rd_next_2;
        end
    end
endmodule

// File: tb/tb_fft_dual_port_mem.sv
// Directed self-checking bench for fft_dual_port_mem (default 32-bit x 16-word build).
module tb_fft_dual_port_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        collision;
    logic        bitrev_en = 1'b0;
    logic [3:0]  write_addr_1 = '0;
    logic [31:0] write_data_1 = '0;
    logic        write_en_1 = 1'b0;
    logic [3:0]  write_addr_2 = '0;
    logic [31:0] write_data_2 = '0;
    logic        write_en_2 = 1'b0;
    logic [3:0]  read_addr_1 = '0;
    logic [31:0] read_data_1;
    logic [3:0]  read_addr_2 = '0;
    logic [31:0] read_data_2;

    int checks = 0;
    int failures = 0;

    fft_dual_port_mem #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy), .collision(collision),
        .bitrev_en(bitrev_en),
        .write_addr_1(write_addr_1), .write_data_1(write_data_1), .write_en_1(write_en_1),
        .write_addr_2(write_addr_2), .write_data_2(write_data_2), .write_en_2(write_en_2),
        .read_addr_1(read_addr_1), .read_data_1(read_data_1),
        .read_addr_2(read_addr_2), .read_data_2(read_data_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || collision !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b collision=%b required busy=1 collision=0", busy, collision);
        end
        checks++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata rd1=%h rd2=%h required 0", read_data_1, read_data_2);
        end
        rst_n = 1'b1;
        write_en_1 = 1'b1; write_addr_1 = 4'h2; write_data_1 = 32'hBAD0BAD0;
        write_en_2 = 1'b1; write_addr_2 = 4'h9; write_data_2 = 32'hBAD1BAD1;
        read_addr_1 = 4'h2;
        cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        write_en_1 = 1'b0; write_en_2 = 1'b0;
        checks++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL reset_busy_len cycles=%0d required 16", cnt);
        end
        for (int a = 0; a < 16; a++) begin
            read_addr_1 = 4'(a);
            read_addr_2 = 4'(15 - a);
            tick();
            checks++;
            if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
                failures++;
                $display("FAIL reset_zero addr=%0d rd1=%h rd2=%h required 0", a, read_data_1, read_data_2);
            end
        end
    endtask

    task automatic test_bitrev();
        bitrev_en = 1'b1;
        write_en_1 = 1'b1; write_addr_1 = 4'h1; write_data_1 = 32'hAAAA0001;
        tick();
        write_en_1 = 1'b0; bitrev_en = 1'b0;
        read_addr_1 = 4'h8; read_addr_2 = 4'h1;
        tick();
        checks++;
        if (read_data_1 !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL bitrev_dst rd1=%h required aaaa0001", read_data_1);
        end
        checks++;
        if (read_data_2 !== 32'h0) begin
            failures++;
            $display("FAIL bitrev_src rd2=%h required 0", read_data_2);
        end
    endtask

    task automatic test_collision();
        write_en_1 = 1'b1; write_addr_1 = 4'h5; write_data_1 = 32'h11111111;
        write_en_2 = 1'b1; write_addr_2 = 4'h5; write_data_2 = 32'h22222222;
        tick();
        write_en_1 = 1'b0; write_en_2 = 1'b0;
        read_addr_1 = 4'h5;
        checks++;
        if (collision !== 1'b1) begin
            failures++;
            $display("FAIL collision_set collision=%b required 1", collision);
        end
        tick();
        checks++;
        if (read_data_1 !== 32'h22222222) begin
            failures++;
            $display("FAIL collision_data rd1=%h required 22222222", read_data_1);
        end
        tick();
        tick();
        checks++;
        if (collision !== 1'b1) begin
            failures++;
            $display("FAIL collision_sticky collision=%b required 1", collision);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp;
        write_en_1 = 1'b1; write_addr_1 = 4'h3; write_data_1 = 32'hDEADBEEF;
        tick();
        write_data_1 = 32'h12345678;
        read_addr_2 = 4'h3;
        tick();
        write_en_1 = 1'b0;
`ifdef FFT_MEM_FWD_EN
        exp = 32'h12345678;
`else
        exp = 32'hDEADBEEF;
`endif
        checks++;
        if (read_data_2 !== exp) begin
            failures++;
            $display("FAIL same_cycle rd2=%h required %h", read_data_2, exp);
        end
        tick();
        checks++;
        if (read_data_2 !== 32'h12345678) begin
            failures++;
            $display("FAIL same_cycle_next rd2=%h required 12345678", read_data_2);
        end
    endtask

    task automatic test_clear_req();
        int cnt;
        for (int a = 0; a < 16; a++) begin
            write_en_2 = 1'b1; write_addr_2 = 4'(a); write_data_2 = 32'hFFFFFFFF;
            tick();
        end
        write_en_2 = 1'b0;
        read_addr_1 = 4'h4;
        tick();
        checks++;
        if (read_data_1 !== 32'hFFFFFFFF || collision !== 1'b1) begin
            failures++;
            $display("FAIL clear_pre rd1=%h collision=%b required ffffffff 1", read_data_1, collision);
        end
        clear_req = 1'b1;
        write_en_2 = 1'b1; write_addr_2 = 4'h0; write_data_2 = 32'h00001234;
        tick();
        clear_req = 1'b0; write_en_2 = 1'b0;
        checks++;
        if (busy !== 1'b1 || collision !== 1'b0) begin
            failures++;
            $display("FAIL clear_accept busy=%b collision=%b required 1 0", busy, collision);
        end
        tick();
        cnt = 1;
        checks++;
        if (read_data_1 !== 32'h0) begin
            failures++;
            $display("FAIL clear_busy_read rd1=%h required 0", read_data_1);
        end
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL clear_busy_len cycles=%0d required 16", cnt);
        end
        for (int a = 0; a < 16; a++) begin
            read_addr_1 = 4'(a);
            tick();
            checks++;
            if (read_data_1 !== 32'h0) begin
                failures++;
                $display("FAIL clear_zero addr=%0d rd1=%h required 0", a, read_data_1);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || read_data_1 !== 32'h0 || collision !== 1'b0) begin
            failures++;
            $display("FAIL midclear_reset busy=%b rd1=%h collision=%b required 1 0 0", busy, read_data_1, collision);
        end
        tick();
        rst_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL midclear_busy_len cycles=%0d required 16", cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        int cnt;
        write_en_1 = 1'b1; write_addr_1 = 4'hA; write_data_1 = 32'h0A0A0A0A;
        write_en_2 = 1'b1; write_addr_2 = 4'hA; write_data_2 = 32'h0B0B0B0B;
        tick();
        write_en_1 = 1'b0; write_en_2 = 1'b0;
        read_addr_1 = 4'hA;
        tick();
        checks++;
        if (read_data_1 !== 32'h0B0B0B0B || collision !== 1'b1) begin
            failures++;
            $display("FAIL midop_pre rd1=%h collision=%b required 0b0b0b0b 1", read_data_1, collision);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || collision !== 1'b0 || read_data_1 !== 32'h0) begin
            failures++;
            $display("FAIL midop_reset busy=%b collision=%b rd1=%h required 1 0 0", busy, collision, read_data_1);
        end
        tick();
        rst_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL midop_busy_len cycles=%0d required 16", cnt);
        end
        tick();
        checks++;
        if (read_data_1 !== 32'h0) begin
            failures++;
            $display("FAIL midop_zero rd1=%h required 0", read_data_1);
        end
    endtask

    initial begin
        test_reset();
        test_bitrev();
        test_collision();
        test_same_cycle();
        test_clear_req();
        test_reset_mid_clear();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
